// File: rtl/mem_pkg.sv
// Shared datamemory definitions: funct3 width codes and the store-buffer entry layout.
package mem_pkg;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [2:0]            funct3;
    } sb_entry_t;

    // Only byte and word stores are supported by the buffer.
    function automatic logic f3_store_legal(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order circular FIFO of store entries; pointers carry one extra bit so
// full and empty are distinguishable. All slots are exposed for hazard checks.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  sb_entry_t push_entry_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output logic [PW:0]   count_o,
    output logic [PW-1:0] head_idx_o,
    output sb_entry_t     entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    logic [PW:0] wr_q, wr_d;
    logic [PW:0] rd_q, rd_d;
    sb_entry_t   mem_q [DEPTH];

    assign wr_d = push_i ? wr_q + 1'b1 : wr_q;
    assign rd_d = pop_i  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry contents need no reset; the valid vector masks stale slots.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q[PW-1:0]] <= push_entry_i;
        end
    end

    assign count_o    = wr_q - rd_q;
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (count_o == (PW+1)'(DEPTH));
    assign head_idx_o = rd_q[PW-1:0];
    assign entries_o  = mem_q;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, PW'(i) - rd_q[PW-1:0]} < count_o);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM stage and datamemory: loads bypass, stores
// drain one per cycle when the port is free, same-word loads stall until drained.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DM_ADDRESS-1:0] st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic [2:0]            st_funct3,
    output logic                  st_err,
    input  logic                  ld_req,
    input  logic [DM_ADDRESS-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    output logic                  ld_stall,
    input  logic                  fence_req,
    output logic                  fence_done,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    output logic [PW:0]           count
);

    logic       full, empty, push, pop, hit, ld_issue, legal;
    logic       st_err_q, st_err_d;
    logic [PW-1:0]    head_idx;
    logic [DEPTH-1:0] valid;
    sb_entry_t        entries [DEPTH];
    sb_entry_t        head;
    sb_entry_t        push_entry;

    assign legal      = f3_store_legal(st_funct3);
    assign st_ready   = !full;
    assign push       = st_valid && !full && legal;
    assign st_err_d   = st_valid && !full && !legal;
    assign push_entry = '{addr: st_addr, data: st_data, funct3: st_funct3};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .head_idx_o   (head_idx),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_err_q <= 1'b0;
        else        st_err_q <= st_err_d;
    end
    assign st_err = st_err_q;

    // Word-granular hazard: any live entry or the store being accepted right now.
    always_comb begin
        hit = push && (st_addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign head       = entries[head_idx];
    assign ld_issue   = ld_req && !hit;
    assign ld_stall   = ld_req && hit;
    assign pop        = !ld_issue && !empty;
    assign fence_done = fence_req && empty;

    // Single datamemory port: an unblocked load wins, otherwise drain the head.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        a        = '0;
        wd       = '0;
        Funct3   = '0;
        if (ld_issue) begin
            MemRead = 1'b1;
            a       = ld_addr;
            Funct3  = ld_funct3;
        end else if (pop) begin
            MemWrite = 1'b1;
            a        = head.addr;
            wd       = head.data;
            Funct3   = head.funct3;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain writes are checked against a queue of
// expected stores, plus per-cycle checks of handshake, hazard and fence outputs.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  st_valid;
    logic                  st_ready;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [DATA_W-1:0]     st_data;
    logic [2:0]            st_funct3;
    logic                  st_err;
    logic                  ld_req;
    logic [DM_ADDRESS-1:0] ld_addr;
    logic [2:0]            ld_funct3;
    logic                  ld_stall;
    logic                  fence_req;
    logic                  fence_done;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [CW-1:0]         count;

    localparam int EW = DM_ADDRESS + DATA_W + 3;
    logic [EW-1:0] exp_q[$];
    int vectors;
    int miscompares;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_funct3  (st_funct3),
        .st_err     (st_err),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_funct3  (ld_funct3),
        .ld_stall   (ld_stall),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .count      (count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_store(input logic [DM_ADDRESS-1:0] ad, input logic [DATA_W-1:0] d,
                               input logic [2:0] f3, input logic expect_accept);
        st_valid  = 1'b1;
        st_addr   = ad;
        st_data   = d;
        st_funct3 = f3;
        if (expect_accept) exp_q.push_back({ad, d, f3});
    endtask

    task automatic drive_load(input logic en, input logic [DM_ADDRESS-1:0] ad);
        ld_req    = en;
        ld_addr   = ad;
        ld_funct3 = F3_LW;
    endtask

    // scoreboard: every drain write must match the oldest expected store
    always @(negedge clk) begin
        if (rst_n && MemWrite) begin
            if (exp_q.size() == 0) begin
                chk("write_with_nothing_pending", MemWrite, 1'b0);
            end else begin
                chk("drain_entry", {a, wd, Funct3}, exp_q.pop_front());
            end
            chk("rw_exclusive", MemRead, 1'b0);
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_req = 1'b0; ld_addr = '0; ld_funct3 = '0;
        fence_req = 1'b0;

        // reset state
        tick(); tick();
        settle();
        chk("rst_st_ready", st_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_a", a, 0);
        chk("rst_st_err", st_err, 0);
        chk("rst_fence_done", fence_done, 0);
        tick();
        rst_n = 1'b1;

        // single SW: no drain in its accept cycle, drained the next
        drive_store(9'h010, 32'hDEADBEEF, F3_SW, 1'b1);
        settle();
        chk("sw_ready", st_ready, 1);
        chk("sw_no_same_cycle_drain", MemWrite, 0);
        tick();
        st_valid = 1'b0;
        settle();
        chk("sw_drain_count", count, 1);
        chk("sw_drain_write", MemWrite, 1);
        chk("sw_drain_f3", Funct3, F3_SW);
        tick();
        settle();
        chk("sw_empty_again", count, 0);
        tick();

        // fill to full behind an unrelated load, then drain in order
        drive_load(1'b1, 9'h100);
        for (int k = 0; k < 5; k++) begin
            drive_store(9'h020 + 9'(4 * k), $urandom(), F3_SW, k < DEPTH);
            settle();
            chk("fill_ready", st_ready, (k < DEPTH) ? 1 : 0);
            chk("fill_count", count, k);
            chk("fill_load_issues", MemRead, 1);
            chk("fill_no_stall", ld_stall, 0);
            tick();
        end
        st_valid = 1'b0;
        drive_load(1'b0, 9'h000);
        for (int j = 0; j < DEPTH; j++) begin
            settle();
            chk("drain_count", count, DEPTH - j);
            chk("drain_write", MemWrite, 1);
            tick();
        end
        settle();
        chk("drain_done", count, 0);
        tick();

        // SB then a same-word LW: one stall cycle, then the load issues
        drive_store(9'h013, 32'h000000AB, F3_SB, 1'b1);
        tick();
        st_valid = 1'b0;
        drive_load(1'b1, 9'h010);
        settle();
        chk("hz_stall", ld_stall, 1);
        chk("hz_drain", MemWrite, 1);
        chk("hz_drain_f3", Funct3, F3_SB);
        chk("hz_no_read", MemRead, 0);
        tick();
        settle();
        chk("hz_released", ld_stall, 0);
        chk("hz_read", MemRead, 1);
        chk("hz_read_addr", a, 9'h010);
        tick();
        drive_load(1'b0, 9'h000);

        // illegal funct3: dropped, one-cycle error pulse
        drive_store(9'h040, 32'h12345678, F3_SH, 1'b0);
        settle();
        chk("err_ready", st_ready, 1);
        chk("err_not_yet", st_err, 0);
        tick();
        st_valid = 1'b0;
        settle();
        chk("err_pulse", st_err, 1);
        chk("err_count", count, 0);
        chk("err_no_write", MemWrite, 0);
        tick();
        settle();
        chk("err_cleared", st_err, 0);
        tick();

        // reset mid-cycle with three stores pending
        drive_load(1'b1, 9'h1F0);
        for (int k = 0; k < 3; k++) begin
            drive_store(9'h060 + 9'(4 * k), $urandom(), F3_SW, 1'b1);
            tick();
        end
        st_valid = 1'b0;
        settle();
        chk("pre_rst_count", count, 3);
        #1;
        rst_n = 1'b0;
        drive_load(1'b0, 9'h000);
        exp_q.delete();
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_write", MemWrite, 0);
        chk("async_rst_ready", st_ready, 1);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("post_rst_no_write", MemWrite, 0);
            tick();
        end

        // fence with two pending stores and one interleaved load
        drive_load(1'b1, 9'h1F0);
        drive_store(9'h080, $urandom(), F3_SW, 1'b1);
        tick();
        drive_store(9'h084, $urandom(), F3_SW, 1'b1);
        tick();
        st_valid = 1'b0;
        drive_load(1'b0, 9'h000);
        fence_req = 1'b1;
        settle();
        chk("fence_cnt2", count, 2);
        chk("fence_busy0", fence_done, 0);
        tick();
        drive_load(1'b1, 9'h1F0);
        settle();
        chk("fence_ld_issue", MemRead, 1);
        chk("fence_ld_nostall", ld_stall, 0);
        chk("fence_ld_nodrain", MemWrite, 0);
        chk("fence_busy1", fence_done, 0);
        tick();
        drive_load(1'b0, 9'h000);
        settle();
        chk("fence_cnt1", count, 1);
        chk("fence_busy2", fence_done, 0);
        tick();
        settle();
        chk("fence_done", fence_done, 1);
        chk("fence_empty", count, 0);
        tick();
        fence_req = 1'b0;
        settle();
        chk("fence_drop", fence_done, 0);
        tick(); tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
